// File: rtl/rmt_deparse_pkg.sv
// Shared definitions for the rmtv2 deparse action sequencer: action slot layout,
// container/select encodings, sequencer FSM states and container region bases.
package rmt_deparse_pkg;

  localparam int SLOT_W        = 16;
  localparam int SLOT_VLD_BIT  = 0;
  localparam int SLOT_IDX_LSB  = 1;
  localparam int SLOT_IDX_W    = 3;
  localparam int SLOT_TYPE_LSB = 4;
  localparam int SLOT_TYPE_W   = 2;
  localparam int SLOT_OFF_LSB  = 6;
  localparam int SLOT_OFF_W    = 7;

  typedef enum logic [1:0] {
    CT_NONE = 2'b00,
    CT_2B   = 2'b01,
    CT_4B   = 2'b10,
    CT_6B   = 2'b11
  } cont_type_e;

  localparam logic [1:0] SEL_2B = 2'b01;
  localparam logic [1:0] SEL_4B = 2'b10;
  localparam logic [1:0] SEL_6B = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_DRAIN,
    ST_OUT
  } seq_state_e;

  // Bit offsets of each container class inside the PHV container region.
  localparam int CONT_2B_BASE = 0;
  localparam int CONT_4B_BASE = 128;
  localparam int CONT_6B_BASE = 384;

  function automatic logic [2:0] sel_to_bytes(input logic [1:0] sel);
    case (sel)
      SEL_2B:  return 3'd2;
      SEL_4B:  return 3'd4;
      SEL_6B:  return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic slot_issuable(input logic [SLOT_W-1:0] slot);
    return slot[SLOT_VLD_BIT] &&
           (slot[SLOT_TYPE_LSB +: SLOT_TYPE_W] != CT_NONE);
  endfunction

endpackage

// File: rtl/hdr_byte_merger.sv
// Combinational overlay of a 2/4/6-byte field onto the header window at a byte
// offset; bytes past the window are dropped and reported through overflow.
module hdr_byte_merger
  import rmt_deparse_pkg::*;
#(
  parameter int C_HDR_WIDTH = 1024
) (
  input  logic [C_HDR_WIDTH-1:0] hdr_in,
  input  logic [47:0]            field,
  input  logic [2:0]             size,
  input  logic [6:0]             offset,
  output logic [C_HDR_WIDTH-1:0] hdr_out,
  output logic                   overflow
);

  localparam int HDR_BYTES = C_HDR_WIDTH / 8;

  logic [7:0] fb [6];

  // fb[k] is field byte k counted from the most significant used byte.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      fb[k] = 8'h00;
      if (k < int'(size)) fb[k] = 8'(field >> (8 * (int'(size) - 1 - k)));
    end
  end

  always_comb begin
    hdr_out = hdr_in;
    for (int j = 0; j < HDR_BYTES; j++) begin
      logic [7:0] rel;
      rel = 8'(j) - {1'b0, offset};
      if ((8'(j) >= {1'b0, offset}) && (rel < {5'b0, size}))
        hdr_out[C_HDR_WIDTH-1-8*j -: 8] = fb[rel[2:0]];
    end
  end

  assign overflow = ({1'b0, offset} + {5'b0, size}) > 8'(HDR_BYTES);

endmodule

// File: rtl/deparse_action_sequencer.sv
// Walks one packet's action list through the 1-cycle extraction lane and merges
// each returned field into the header. Optional error counter: SEQ_ERR_CNT_EN.
module deparse_action_sequencer
  import rmt_deparse_pkg::*;
#(
  parameter int C_HDR_WIDTH        = 1024,
  parameter int C_PHV_CONT_WIDTH   = 768,
  parameter int C_NUM_ACT          = 10,
  parameter int C_ACT_WIDTH        = 16,
  parameter int C_PARSE_ACTION_LEN = 6
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [C_HDR_WIDTH-1:0]            req_hdr,
  input  logic [C_PHV_CONT_WIDTH-1:0]       req_phv,
  input  logic [C_NUM_ACT*C_ACT_WIDTH-1:0]  req_actions,
  output logic [C_PHV_CONT_WIDTH-1:0]       lane_phv,
  output logic                              lane_phv_valid,
  output logic [C_PARSE_ACTION_LEN-1:0]     lane_action,
  output logic                              lane_action_valid,
  input  logic [47:0]                       lane_data,
  input  logic [1:0]                        lane_select,
  input  logic                              lane_valid,
  output logic [C_HDR_WIDTH-1:0]            hdr_out,
  output logic                              hdr_out_valid,
  input  logic                              hdr_out_ready,
  output logic                              busy
`ifdef SEQ_ERR_CNT_EN
  ,
  output logic [15:0]                       err_cnt
`endif
);

  localparam int CNT_W = $clog2(C_NUM_ACT);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid and payload stable until then.
  seq_state_e                       state;
  logic [CNT_W-1:0]                 slot_cnt;
  logic [CNT_W-1:0]                 nxt_idx;
  logic [C_HDR_WIDTH-1:0]           hdr_q;
  logic [C_HDR_WIDTH-1:0]           merged;
  logic [C_PHV_CONT_WIDTH-1:0]      phv_q;
  logic [C_NUM_ACT*C_ACT_WIDTH-1:0] act_q;
  logic [C_ACT_WIDTH-1:0]           cur_slot;
  logic [C_ACT_WIDTH-1:0]           nxt_slot;
  logic                             pipe_vld;
  logic [SLOT_OFF_W-1:0]            pipe_off;
  logic [2:0]                       merge_size;
  logic                             merge_en;
  logic                             merge_ovf;
  logic                             last_slot;
  logic                             unused_bits;

  assign nxt_idx    = (state == ST_LOAD) ? '0 : slot_cnt + 1'b1;
  assign cur_slot   = C_ACT_WIDTH'(act_q >> (C_ACT_WIDTH * slot_cnt));
  assign nxt_slot   = C_ACT_WIDTH'(act_q >> (C_ACT_WIDTH * nxt_idx));
  assign last_slot  = (slot_cnt == CNT_W'(C_NUM_ACT - 1));
  assign merge_size = sel_to_bytes(lane_select);

  // The pipe only holds an entry for a slot issued in the previous cycle, so a
  // stray lane strobe with nothing issued behind it is never merged.
  assign merge_en = lane_valid && pipe_vld &&
                    (((state == ST_ISSUE) && (slot_cnt != '0)) || (state == ST_DRAIN));

  assign lane_phv = phv_q;
  assign hdr_out  = hdr_q;
  assign busy     = (state != ST_IDLE);

  hdr_byte_merger #(
    .C_HDR_WIDTH (C_HDR_WIDTH)
  ) u_merger (
    .hdr_in   (hdr_q),
    .field    (lane_data),
    .size     (merge_size),
    .offset   (pipe_off),
    .hdr_out  (merged),
    .overflow (merge_ovf)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state             <= ST_IDLE;
      req_ready         <= 1'b0;
      hdr_out_valid     <= 1'b0;
      lane_phv_valid    <= 1'b0;
      lane_action_valid <= 1'b0;
      lane_action       <= '0;
      slot_cnt          <= '0;
      hdr_q             <= '0;
      phv_q             <= '0;
      act_q             <= '0;
      pipe_vld          <= 1'b0;
      pipe_off          <= '0;
    end else begin
      lane_phv_valid    <= 1'b0;
      lane_action_valid <= 1'b0;
      lane_action       <= '0;
      pipe_vld          <= lane_action_valid;
      pipe_off          <= cur_slot[SLOT_OFF_LSB +: SLOT_OFF_W];
      if (merge_en) hdr_q <= merged;

      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            hdr_q          <= req_hdr;
            phv_q          <= req_phv;
            act_q          <= req_actions;
            req_ready      <= 1'b0;
            lane_phv_valid <= 1'b1;
            state          <= ST_LOAD;
          end
        end
        ST_LOAD, ST_ISSUE: begin
          if ((state == ST_ISSUE) && last_slot) begin
            state <= ST_DRAIN;
          end else begin
            slot_cnt <= nxt_idx;
            state    <= ST_ISSUE;
            // Outputs are registered, so the slot shown next cycle is decided now.
            if (slot_issuable(nxt_slot)) begin
              lane_action_valid <= 1'b1;
              lane_action       <= nxt_slot[C_PARSE_ACTION_LEN-1:0];
            end
          end
        end
        ST_DRAIN: begin
          hdr_out_valid <= 1'b1;
          state         <= ST_OUT;
        end
        ST_OUT: begin
          if (hdr_out_ready) begin
            hdr_out_valid <= 1'b0;
            req_ready     <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SEQ_ERR_CNT_EN
  logic        err_bad_slot;
  logic        err_ovf;
  logic [16:0] err_sum;

  assign err_bad_slot = (state == ST_ISSUE) && cur_slot[SLOT_VLD_BIT] &&
                        (cur_slot[SLOT_TYPE_LSB +: SLOT_TYPE_W] == CT_NONE);
  assign err_ovf      = merge_en && merge_ovf;
  assign err_sum      = {1'b0, err_cnt} + 17'(err_bad_slot) + 17'(err_ovf);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) err_cnt <= '0;
    else          err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end
`endif

  assign unused_bits = ^{nxt_slot[C_ACT_WIDTH-1:C_PARSE_ACTION_LEN],
                         cur_slot[C_ACT_WIDTH-1:SLOT_OFF_LSB+SLOT_OFF_W],
                         cur_slot[SLOT_OFF_LSB-1:0], merge_ovf};

endmodule

// File: tb/tb_deparse_action_sequencer.sv
// Bench for deparse_action_sequencer with a behavioural 1-cycle lane model.
// Table-driven vectors plus backpressure and mid-packet reset sequences.
module tb_deparse_action_sequencer;
  import rmt_deparse_pkg::*;

  localparam int HW   = 1024;
  localparam int PW   = 768;
  localparam int NA   = 10;
  localparam int AW   = 16;
  localparam int AL   = 6;
  localparam int ACTW = NA * AW;
  localparam int NV   = 8;

  typedef struct {
    logic [HW-1:0]   hdr;
    logic [PW-1:0]   phv;
    logic [ACTW-1:0] acts;
    logic [HW-1:0]   exp_hdr;
    int              exp_err;
    int              exp_iss;
  } vec_t;

  logic            clk;
  logic            aresetn;
  logic            req_valid;
  logic            req_ready;
  logic [HW-1:0]   req_hdr;
  logic [PW-1:0]   req_phv;
  logic [ACTW-1:0] req_actions;
  logic [PW-1:0]   lane_phv;
  logic            lane_phv_valid;
  logic [AL-1:0]   lane_action;
  logic            lane_action_valid;
  logic [47:0]     lane_data;
  logic [1:0]      lane_select;
  logic            lane_valid;
  logic [HW-1:0]   hdr_out;
  logic            hdr_out_valid;
  logic            hdr_out_ready;
  logic            busy;
`ifdef SEQ_ERR_CNT_EN
  logic [15:0]     err_cnt;
`endif

  deparse_action_sequencer dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_hdr           (req_hdr),
    .req_phv           (req_phv),
    .req_actions       (req_actions),
    .lane_phv          (lane_phv),
    .lane_phv_valid    (lane_phv_valid),
    .lane_action       (lane_action),
    .lane_action_valid (lane_action_valid),
    .lane_data         (lane_data),
    .lane_select       (lane_select),
    .lane_valid        (lane_valid),
    .hdr_out           (hdr_out),
    .hdr_out_valid     (hdr_out_valid),
    .hdr_out_ready     (hdr_out_ready),
    .busy              (busy)
`ifdef SEQ_ERR_CNT_EN
    ,
    .err_cnt           (err_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_total = 0;
  logic [HW-1:0] exp_q[$];
  vec_t vecs[NV];

  // ---------------- helpers ----------------
  function automatic logic [47:0] lane_field(input logic [PW-1:0] p, input logic [2:0] idx,
                                             input logic [1:0] t);
    case (t)
      2'b01:   return 48'(p >> (CONT_2B_BASE + 16 * int'(idx))) & 48'h0000_0000_FFFF;
      2'b10:   return 48'(p >> (CONT_4B_BASE + 32 * int'(idx))) & 48'h0000_FFFF_FFFF;
      2'b11:   return 48'(p >> (CONT_6B_BASE + 48 * int'(idx)));
      default: return 48'h0;
    endcase
  endfunction

  function automatic logic [HW-1:0] put_byte(input logic [HW-1:0] h, input int j,
                                             input logic [7:0] b);
    logic [HW-1:0] m;
    m = HW'(8'hFF) << (HW - 8 - 8 * j);
    return (h & ~m) | (HW'(b) << (HW - 8 - 8 * j));
  endfunction

  function automatic logic [7:0] get_byte(input logic [HW-1:0] h, input int j);
    return 8'(h >> (HW - 8 - 8 * j));
  endfunction

  function automatic logic [PW-1:0] put_cont(input logic [PW-1:0] p, input int lsb, input int w,
                                             input logic [47:0] val);
    logic [PW-1:0] m;
    m = ((PW'(1) << w) - PW'(1)) << lsb;
    return (p & ~m) | ((PW'(val) << lsb) & m);
  endfunction

  function automatic logic [15:0] mk_slot(input int v, input int idx, input int t, input int off);
    return {3'b000, 7'(off), 2'(t), 3'(idx), 1'(v)};
  endfunction

  function automatic logic [ACTW-1:0] put_slot(input logic [ACTW-1:0] a, input int s,
                                               input logic [15:0] sl);
    logic [ACTW-1:0] m;
    m = ACTW'(16'hFFFF) << (16 * s);
    return (a & ~m) | (ACTW'(sl) << (16 * s));
  endfunction

  function automatic logic [HW-1:0] rand_hdr();
    logic [HW-1:0] h;
    h = '0;
    for (int w = 0; w < HW / 32; w++) h = (h << 32) | HW'($urandom);
    return h;
  endfunction

  function automatic logic [PW-1:0] rand_phv();
    logic [PW-1:0] p;
    p = '0;
    for (int w = 0; w < PW / 32; w++) p = (p << 32) | PW'($urandom);
    return p;
  endfunction

  // Reference: apply slots in order, byte by byte, MSB of the field first.
  function automatic void model(input logic [HW-1:0] h, input logic [PW-1:0] p,
                                input logic [ACTW-1:0] a, output logic [HW-1:0] r,
                                output int e, output int iss);
    r = h; e = 0; iss = 0;
    for (int s = 0; s < NA; s++) begin
      logic [15:0] sl;
      logic [47:0] fld;
      int n, off;
      bit drop;
      sl = 16'(a >> (16 * s));
      off = int'(sl[12:6]);
      if (sl[0] && sl[5:4] == 2'b00) e++;
      else if (sl[0]) begin
        iss++;
        n = 2 * int'(sl[5:4]);
        fld = lane_field(p, sl[3:1], sl[5:4]);
        drop = 0;
        for (int k = 0; k < n; k++) begin
          if (off + k > 127) drop = 1;
          else r = put_byte(r, off + k, 8'(fld >> (8 * (n - 1 - k))));
        end
        if (drop) e++;
      end
    end
  endfunction

  // ---------------- lane model and monitor ----------------
  logic [PW-1:0] lphv;
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      lane_valid  <= 1'b0;
      lane_data   <= '0;
      lane_select <= '0;
      lphv        <= '0;
    end else begin
      lane_valid <= lane_action_valid;
      if (lane_phv_valid) lphv <= lane_phv;
      if (lane_action_valid) begin
        lane_select <= lane_action[5:4];
        lane_data   <= lane_field(lphv, lane_action[3:1], lane_action[5:4]);
      end
    end
  end

  int act_seen, act_bad, phv_seen, phv_bad;
  logic [PW-1:0] cur_phv;
  always @(negedge clk) begin
    if (lane_action_valid) begin
      act_seen++;
      if (!lane_action[0] || lane_action[5:4] == 2'b00) act_bad++;
    end
    if (lane_phv_valid) begin
      phv_seen++;
      if (lane_phv !== cur_phv) phv_bad++;
    end
  end

  // ---------------- checkers ----------------
  task automatic chk_int(input string nm, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic chk_hdr(input string nm, input logic [HW-1:0] a, input logic [HW-1:0] e);
    checks++;
    if (a !== e) begin
      int j;
      errors++;
      j = 0;
      while (j < 127 && get_byte(a, j) === get_byte(e, j)) j++;
      $display("FAIL %s byte %0d got %02h want %02h", nm, j, get_byte(a, j), get_byte(e, j));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input vec_t v);
    int t;
    exp_q.push_back(v.exp_hdr);
    err_total += v.exp_err;
    cur_phv  = v.phv;
    act_seen = 0; act_bad = 0; phv_seen = 0; phv_bad = 0;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk_int("req_ready_wait", int'(req_ready), 1);
    req_hdr     = v.hdr;
    req_phv     = v.phv;
    req_actions = v.acts;
    req_valid   = 1'b1;
    @(negedge clk);
    req_valid   = 1'b0;
  endtask

  task automatic receive(input string nm, input int exp_iss, input int hold);
    int lat;
    logic [HW-1:0] exp_h, first;
    lat = 1;
    while (!hdr_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk_int({nm, "_latency"}, lat, NA + 3);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_scoreboard got empty queue want entry", nm);
      exp_h = '0;
    end else exp_h = exp_q.pop_front();
    chk_hdr({nm, "_hdr"}, hdr_out, exp_h);
    chk_int({nm, "_issued"}, act_seen, exp_iss);
    chk_int({nm, "_bad_issue"}, act_bad, 0);
    chk_int({nm, "_phv_load"}, phv_seen * 2 + phv_bad, 2);
`ifdef SEQ_ERR_CNT_EN
    chk_int({nm, "_err_cnt"}, int'(err_cnt), err_total);
`endif
    first = hdr_out;
    for (int h = 0; h < hold; h++) begin
      chk_int({nm, "_hold_valid"}, int'(hdr_out_valid), 1);
      chk_int({nm, "_hold_ready"}, int'(req_ready), 0);
      chk_hdr({nm, "_hold_stable"}, hdr_out, first);
      @(negedge clk);
    end
    hdr_out_ready = 1'b1;
    @(negedge clk);
    hdr_out_ready = 1'b0;
    chk_int({nm, "_done_valid"}, int'(hdr_out_valid), 0);
    chk_int({nm, "_done_busy"}, int'(busy), 0);
    chk_int({nm, "_done_ready"}, int'(req_ready), 1);
  endtask

  // ---------------- test ----------------
  initial begin
    int seen;
    aresetn = 1'b0; req_valid = 1'b0; hdr_out_ready = 1'b0;
    req_hdr = '0; req_phv = '0; req_actions = '0; cur_phv = '0;
    act_seen = 0; act_bad = 0; phv_seen = 0; phv_bad = 0;

    // table fill
    for (int i = 0; i < NV; i++) begin
      vecs[i].hdr = rand_hdr(); vecs[i].phv = rand_phv(); vecs[i].acts = '0;
    end
    vecs[0].phv  = put_cont(vecs[0].phv, 0, 16, 48'hABCD);
    vecs[0].acts = put_slot('0, 0, mk_slot(1, 0, 1, 12));
    vecs[0].exp_hdr = put_byte(put_byte(vecs[0].hdr, 12, 8'hAB), 13, 8'hCD);
    vecs[0].exp_err = 0; vecs[0].exp_iss = 1;

    for (int s = 0; s < NA; s++)
      vecs[1].acts = put_slot(vecs[1].acts, s, mk_slot(0, s % 8, (s % 3) + 1, s * 10));
    vecs[1].exp_hdr = vecs[1].hdr; vecs[1].exp_err = 0; vecs[1].exp_iss = 0;

    vecs[2].phv  = put_cont(vecs[2].phv, CONT_6B_BASE + 96, 48, 48'h010203040506);
    vecs[2].acts = put_slot('0, 0, mk_slot(1, 2, 3, 124));
    vecs[2].exp_hdr = put_byte(put_byte(put_byte(put_byte(vecs[2].hdr,
                      124, 8'h01), 125, 8'h02), 126, 8'h03), 127, 8'h04);
    vecs[2].exp_err = 1; vecs[2].exp_iss = 1;

    vecs[3].phv  = put_cont(vecs[3].phv, CONT_4B_BASE + 32, 32, 48'h11223344);
    vecs[3].phv  = put_cont(vecs[3].phv, 80, 16, 48'hEEFF);
    vecs[3].acts = put_slot(put_slot('0, 0, mk_slot(1, 1, 2, 20)), 1, mk_slot(1, 5, 1, 22));
    vecs[3].exp_hdr = put_byte(put_byte(put_byte(put_byte(vecs[3].hdr,
                      20, 8'h11), 21, 8'h22), 22, 8'hEE), 23, 8'hFF);
    vecs[3].exp_err = 0; vecs[3].exp_iss = 2;

    // overflow merge and type-00 slot land in the same cycle; slot 9 merges in DRAIN
    vecs[4].acts = put_slot(vecs[4].acts, 3, mk_slot(1, 7, 3, 126));
    vecs[4].acts = put_slot(vecs[4].acts, 4, mk_slot(1, 0, 0, 50));
    vecs[4].acts = put_slot(vecs[4].acts, 9, mk_slot(1, 7, 1, 0));
    begin
      int e, iss;
      model(vecs[4].hdr, vecs[4].phv, vecs[4].acts, vecs[4].exp_hdr, e, iss);
    end
    vecs[4].exp_err = 2; vecs[4].exp_iss = 2;

    for (int i = 5; i < NV; i++) begin
      for (int s = 0; s < NA; s++) begin
        int off;
        off = ($urandom_range(0, 3) == 0) ? $urandom_range(120, 127) : $urandom_range(0, 127);
        vecs[i].acts = put_slot(vecs[i].acts, s, mk_slot($urandom_range(0, 3) != 0,
                       $urandom_range(0, 7), $urandom_range(0, 3), off));
      end
      model(vecs[i].hdr, vecs[i].phv, vecs[i].acts, vecs[i].exp_hdr,
            vecs[i].exp_err, vecs[i].exp_iss);
    end

    // reset state
    repeat (3) @(negedge clk);
    chk_int("rst_req_ready", int'(req_ready), 0);
    chk_int("rst_out_valid", int'(hdr_out_valid), 0);
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_lane_act", int'(lane_action_valid), 0);
    chk_int("rst_lane_phv", int'(lane_phv_valid), 0);
    chk_hdr("rst_hdr_out", hdr_out, '0);
`ifdef SEQ_ERR_CNT_EN
    chk_int("rst_err_cnt", int'(err_cnt), 0);
`endif
    aresetn = 1'b1;
    @(negedge clk);
    chk_int("idle_req_ready", int'(req_ready), 1);

    for (int i = 0; i < NV; i++) begin
      send(vecs[i]);
      receive($sformatf("vec%0d", i), vecs[i].exp_iss, 0);
    end

    // backpressure: ready low for 5 valid cycles
    send(vecs[0]);
    receive("backpressure", vecs[0].exp_iss, 5);

    // reset in the middle of ISSUE (cycle 5 after acceptance)
    send(vecs[3]);
    repeat (4) @(negedge clk);
    aresetn = 1'b0;
    #1;
    chk_int("midrst_req_ready", int'(req_ready), 0);
    chk_int("midrst_out_valid", int'(hdr_out_valid), 0);
    chk_int("midrst_busy", int'(busy), 0);
    chk_int("midrst_lane_act", int'(lane_action_valid) + int'(lane_action), 0);
    chk_hdr("midrst_hdr_out", hdr_out, '0);
    exp_q.delete();
    err_total = 0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (hdr_out_valid) seen++;
    end
    chk_int("midrst_no_output", seen, 0);
    send(vecs[2]);
    receive("after_reset", vecs[2].exp_iss, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
